// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS waveform source.
package dds_pkg;

  localparam int PHASE_W = 32;
  localparam int ACC_W   = 14;
  localparam int PROD_W  = 37;

  localparam int unsigned CLK_HZ_DEFAULT = 32'd50_000_000;

  // tw = f * 2^32 / CLK_HZ = (f * K_Q16) >> 16, with K_Q16 = round(2^48 / CLK_HZ).
  function automatic int unsigned k_q16_of(input int unsigned clk_hz);
    return 32'(((64'd1 << 48) + 64'(clk_hz / 32'd2)) / 64'(clk_hz));
  endfunction

  localparam int unsigned K_Q16_DEFAULT = k_q16_of(CLK_HZ_DEFAULT);

  typedef enum logic [1:0] {
    SINE   = 2'd0,
    SQUARE = 2'd1,
    TRI    = 2'd2,
    SAW    = 2'd3
  } wave_sel_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    C0     = 3'd1,
    C1     = 3'd2,
    C2     = 3'd3,
    C3     = 3'd4,
    MUL    = 3'd5,
    COMMIT = 3'd6
  } dds_state_t;

  typedef logic [3:0] bcd_digit_t;

  function automatic logic bcd_ok(input bcd_digit_t d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/dds_wave_gen_sine_lut.sv
// Quarter-wave sine ROM: data = round(127*sin(pi*addr/128)), registered output.
module dds_sine_lut (
  input  logic       clk,
  input  logic       rstn,
  input  logic [5:0] addr,
  output logic [6:0] data
);

  logic [6:0] data_q, data_d;

  // ROM contents
  always_comb begin
    data_d = 7'd0;
    case (addr)
      6'd0:  data_d = 7'd0;   6'd1:  data_d = 7'd3;   6'd2:  data_d = 7'd6;   6'd3:  data_d = 7'd9;
      6'd4:  data_d = 7'd12;  6'd5:  data_d = 7'd16;  6'd6:  data_d = 7'd19;  6'd7:  data_d = 7'd22;
      6'd8:  data_d = 7'd25;  6'd9:  data_d = 7'd28;  6'd10: data_d = 7'd31;  6'd11: data_d = 7'd34;
      6'd12: data_d = 7'd37;  6'd13: data_d = 7'd40;  6'd14: data_d = 7'd43;  6'd15: data_d = 7'd46;
      6'd16: data_d = 7'd49;  6'd17: data_d = 7'd51;  6'd18: data_d = 7'd54;  6'd19: data_d = 7'd57;
      6'd20: data_d = 7'd60;  6'd21: data_d = 7'd63;  6'd22: data_d = 7'd65;  6'd23: data_d = 7'd68;
      6'd24: data_d = 7'd71;  6'd25: data_d = 7'd73;  6'd26: data_d = 7'd76;  6'd27: data_d = 7'd78;
      6'd28: data_d = 7'd81;  6'd29: data_d = 7'd83;  6'd30: data_d = 7'd85;  6'd31: data_d = 7'd88;
      6'd32: data_d = 7'd90;  6'd33: data_d = 7'd92;  6'd34: data_d = 7'd94;  6'd35: data_d = 7'd96;
      6'd36: data_d = 7'd98;  6'd37: data_d = 7'd100; 6'd38: data_d = 7'd102; 6'd39: data_d = 7'd104;
      6'd40: data_d = 7'd106; 6'd41: data_d = 7'd107; 6'd42: data_d = 7'd109; 6'd43: data_d = 7'd111;
      6'd44: data_d = 7'd112; 6'd45: data_d = 7'd113; 6'd46: data_d = 7'd115; 6'd47: data_d = 7'd116;
      6'd48: data_d = 7'd117; 6'd49: data_d = 7'd118; 6'd50: data_d = 7'd120; 6'd51: data_d = 7'd121;
      6'd52: data_d = 7'd122; 6'd53: data_d = 7'd122; 6'd54: data_d = 7'd123; 6'd55: data_d = 7'd124;
      6'd56: data_d = 7'd125; 6'd57: data_d = 7'd125; 6'd58: data_d = 7'd126; 6'd59: data_d = 7'd126;
      6'd60: data_d = 7'd126; 6'd61: data_d = 7'd127; 6'd62: data_d = 7'd127; 6'd63: data_d = 7'd127;
      default: data_d = 7'd0;
    endcase
  end

  // ROM output register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q <= 7'd0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data = data_q;

endmodule

// File: rtl/dds_wave_gen.sv
// DDS source: sequential BCD-to-tuning-word conversion, 32-bit phase accumulator
// and a two-stage shaper producing sine/square/triangle/sawtooth samples.
module dds_wave_gen
  import dds_pkg::*;
#(
  parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT,
  parameter int unsigned K_Q16  = k_q16_of(CLK_HZ)
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  freq_thou,
  input  logic [3:0]  freq_hund,
  input  logic [3:0]  freq_ten,
  input  logic [3:0]  freq_one,
  input  logic        freq_load,
  input  logic [1:0]  wave_sel,
  output logic [7:0]  wave_out,
  output logic [13:0] freq_bin,
  output logic        busy,
  output logic        bcd_err
);

  dds_state_t         state_q, state_d;
  logic [15:0]        digits_q, digits_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [PROD_W-1:0]  prod_q, prod_d;
  logic [PHASE_W-1:0] tw_q, tw_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [ACC_W-1:0]   freq_bin_q, freq_bin_d;
  logic               busy_q, busy_d;
  logic               bcd_err_q, bcd_err_d;
  logic               digits_ok_s;

  assign digits_ok_s = bcd_ok(freq_thou) & bcd_ok(freq_hund) & bcd_ok(freq_ten) & bcd_ok(freq_one);

  // Conversion FSM next-state and datapath
  always_comb begin
    state_d    = state_q;
    digits_d   = digits_q;
    acc_d      = acc_q;
    prod_d     = prod_q;
    tw_d       = tw_q;
    freq_bin_d = freq_bin_q;
    bcd_err_d  = bcd_err_q;
    case (state_q)
      IDLE: begin
        if (freq_load) begin
          if (digits_ok_s) begin
            digits_d  = {freq_thou, freq_hund, freq_ten, freq_one};
            bcd_err_d = 1'b0;
            state_d   = C0;
          end else begin
            bcd_err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      C0: begin
        acc_d   = {10'd0, digits_q[15:12]};
        state_d = C1;
      end
      C1: begin
        acc_d   = acc_q * 14'd10 + {10'd0, digits_q[11:8]};
        state_d = C2;
      end
      C2: begin
        acc_d   = acc_q * 14'd10 + {10'd0, digits_q[7:4]};
        state_d = C3;
      end
      C3: begin
        acc_d   = acc_q * 14'd10 + {10'd0, digits_q[3:0]};
        state_d = MUL;
      end
      MUL: begin
        prod_d  = PROD_W'(acc_q) * PROD_W'(K_Q16);
        state_d = COMMIT;
      end
      COMMIT: begin
        tw_d       = PHASE_W'(prod_q >> 16);
        freq_bin_d = acc_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Conversion FSM state and its registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      digits_q   <= 16'd0;
      acc_q      <= 14'd0;
      prod_q     <= 37'd0;
      tw_q       <= 32'd0;
      freq_bin_q <= 14'd0;
      busy_q     <= 1'b0;
      bcd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      digits_q   <= digits_d;
      acc_q      <= acc_d;
      prod_q     <= prod_d;
      tw_q       <= tw_d;
      freq_bin_q <= freq_bin_d;
      busy_q     <= busy_d;
      bcd_err_q  <= bcd_err_d;
    end
  end

  assign phase_d = phase_q + tw_q;

  // Phase accumulator; retuning only changes the step, never the phase
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase_q <= 32'd0;
    end else begin
      phase_q <= phase_d;
    end
  end

  logic [8:0] ph1_q, ph1_d;
  wave_sel_t  sel1_q, sel1_d;
  logic [5:0] lut_addr_s;
  logic [6:0] lut_data_s;
  logic [6:0] tri_s;
  logic [7:0] wave_q, wave_d;

  assign ph1_d      = phase_q[31:23];
  assign sel1_d     = wave_sel_t'(wave_sel);
  // Quadrants 1 and 3 (phase[30] set) walk the quarter-wave table backwards
  assign lut_addr_s = phase_q[30] ? ~phase_q[29:24] : phase_q[29:24];

  dds_sine_lut u_lut (
    .clk  (clk),
    .rstn (rstn),
    .addr (lut_addr_s),
    .data (lut_data_s)
  );

  // Shaping stage 1: phase bits and selection, aligned with the ROM output register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ph1_q  <= 9'd0;
      sel1_q <= SINE;
    end else begin
      ph1_q  <= ph1_d;
      sel1_q <= sel1_d;
    end
  end

  // Shape mux; ph1_q = phase[31:23], so ph1_q[8] is the half bit
  always_comb begin
    tri_s = ph1_q[7] ? ~ph1_q[6:0] : ph1_q[6:0];
    case (sel1_q)
      SINE:    wave_d = ph1_q[8] ? (8'd127 - {1'b0, lut_data_s}) : (8'd128 + {1'b0, lut_data_s});
      SQUARE:  wave_d = ph1_q[8] ? 8'h00 : 8'hFF;
      TRI:     wave_d = ph1_q[8] ? (8'd127 - {1'b0, tri_s}) : (8'd128 + {1'b0, tri_s});
      SAW:     wave_d = ph1_q[8:1] ^ 8'h80;
      default: wave_d = 8'h80;
    endcase
  end

  // Shaping stage 2: registered sample
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wave_q <= 8'h80;
    end else begin
      wave_q <= wave_d;
    end
  end

  assign wave_out = wave_q;
  assign freq_bin = freq_bin_q;
  assign busy     = busy_q;
  assign bcd_err  = bcd_err_q;

endmodule

// File: tb/tb_dds_wave_gen.sv
// Directed bench for dds_wave_gen: conversion timing, BCD rejection, period, shapes, reset abort.
module tb_dds_wave_gen;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  freq_thou, freq_hund, freq_ten, freq_one;
  logic        freq_load;
  logic [1:0]  wave_sel;
  logic [7:0]  wave_out;
  logic [13:0] freq_bin;
  logic        busy;
  logic        bcd_err;

  int total = 0;
  int bad   = 0;

  dds_wave_gen dut (
    .clk       (clk),
    .rstn      (rstn),
    .freq_thou (freq_thou),
    .freq_hund (freq_hund),
    .freq_ten  (freq_ten),
    .freq_one  (freq_one),
    .freq_load (freq_load),
    .wave_sel  (wave_sel),
    .wave_out  (wave_out),
    .freq_bin  (freq_bin),
    .busy      (busy),
    .bcd_err   (bcd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge just after the accepting edge
  task automatic do_load(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    freq_thou = a; freq_hund = b; freq_ten = c; freq_one = d;
    freq_load = 1'b1;
    @(negedge clk);
    freq_load = 1'b0;
    freq_thou = 4'd0; freq_hund = 4'd0; freq_ten = 4'd0; freq_one = 4'd0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_edge(input logic rise, input int budget, output int cycles, output logic ok);
    logic prev;
    prev   = wave_out[7];
    cycles = 0;
    ok     = 1'b0;
    while (!ok && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (wave_out[7] === rise && prev === ~rise) ok = 1'b1;
      prev = wave_out[7];
    end
  endtask

  initial begin
    int errs, nb, c, c1, c2, last_t, ntrans, nbadv, mn, mx;
    logic ok;
    logic [7:0] prevv;

    rstn = 1'b0; freq_load = 1'b0; wave_sel = 2'd0;
    freq_thou = 4'd0; freq_hund = 4'd0; freq_ten = 4'd0; freq_one = 4'd0;
    tick(3);
    chk("rst_wave", 32'(wave_out), 32'h80);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_freq_bin", 32'(freq_bin), 32'd0);
    chk("rst_bcd_err", 32'(bcd_err), 32'd0);
    rstn = 1'b1;

    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (wave_out !== 8'h80) errs++;
    end
    chk("idle_const", 32'(errs), 32'd0);
    chk("idle_tw", dut.tw_q, 32'd0);

    // 1000 Hz: busy length, commit latency, tuning word
    do_load(4'd1, 4'd0, 4'd0, 4'd0);
    nb = 0;
    while (busy === 1'b1 && nb < 20) begin
      nb++;
      if (nb == 6) chk("pre_commit_freq_bin", 32'(freq_bin), 32'd0);
      @(negedge clk);
    end
    chk("busy_len", 32'(nb), 32'd6);
    chk("f1000_freq_bin", 32'(freq_bin), 32'd1000);
    chk("f1000_tw", dut.tw_q, 32'd85899);

    wait_edge(1'b0, 60000, c, ok);
    chk("f1000_fall_seen", 32'(ok), 32'd1);
    wait_edge(1'b1, 60000, c, ok);
    chk("f1000_rise_seen", 32'(ok), 32'd1);
    chk("f1000_half_period", 32'(c >= 24999 && c <= 25001), 32'd1);

    // 9999 Hz, with a second load during busy that must be ignored
    do_load(4'd9, 4'd9, 4'd9, 4'd9);
    chk("f9999_busy", 32'(busy), 32'd1);
    do_load(4'd0, 4'd0, 4'd0, 4'd1);
    wait_idle("f9999_idle");
    tick(10);
    chk("f9999_freq_bin", 32'(freq_bin), 32'd9999);
    chk("f9999_tw", dut.tw_q, 32'd858907);
    chk("ignored_load_busy", 32'(busy), 32'd0);
    wait_edge(1'b1, 12000, c, ok);
    wait_edge(1'b1, 12000, c1, ok);
    wait_edge(1'b1, 12000, c2, ok);
    chk("f9999_period_a", 32'(c1 == 5000 || c1 == 5001), 32'd1);
    chk("f9999_period_b", 32'(c2 == 5000 || c2 == 5001), 32'd1);

    // Rejected load, then a valid one that clears the error
    do_load(4'd1, 4'd2, 4'hA, 4'd4);
    chk("bad_bcd_err", 32'(bcd_err), 32'd1);
    chk("bad_bcd_busy", 32'(busy), 32'd0);
    tick(3);
    chk("bad_bcd_busy_later", 32'(busy), 32'd0);
    chk("bad_bcd_tw", dut.tw_q, 32'd858907);
    chk("bad_bcd_freq_bin", 32'(freq_bin), 32'd9999);
    do_load(4'd0, 4'd0, 4'd5, 4'd0);
    chk("f50_err_clear", 32'(bcd_err), 32'd0);
    chk("f50_busy", 32'(busy), 32'd1);
    wait_idle("f50_idle");
    chk("f50_freq_bin", 32'(freq_bin), 32'd50);
    chk("f50_tw", dut.tw_q, 32'd4294);

    // Shapes at one p-step per cycle
    force dut.tw_q = 32'h0100_0000;
    wave_sel = 2'd3;
    tick(4);
    errs = 0;
    prevv = wave_out;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (wave_out !== prevv + 8'd1) errs++;
      prevv = wave_out;
    end
    chk("saw_step", 32'(errs), 32'd0);

    wave_sel = 2'd1;
    tick(4);
    prevv = wave_out; last_t = -1; ntrans = 0; errs = 0; nbadv = 0;
    for (int i = 1; i < 512; i++) begin
      @(negedge clk);
      if (wave_out !== 8'h00 && wave_out !== 8'hFF) nbadv++;
      if (wave_out !== prevv) begin
        if (last_t >= 0 && (i - last_t) != 128) errs++;
        last_t = i;
        ntrans++;
      end
      prevv = wave_out;
    end
    chk("sq_values", 32'(nbadv), 32'd0);
    chk("sq_run_len", 32'(errs), 32'd0);
    chk("sq_transitions", 32'(ntrans >= 3), 32'd1);

    wave_sel = 2'd2;
    tick(4);
    mn = 255; mx = 0;
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      if (int'(wave_out) < mn) mn = int'(wave_out);
      if (int'(wave_out) > mx) mx = int'(wave_out);
    end
    chk("tri_max", 32'(mx), 32'd255);
    chk("tri_min", 32'(mn), 32'd0);

    wave_sel = 2'd0;
    tick(4);
    mn = 255; mx = 0;
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      if (int'(wave_out) < mn) mn = int'(wave_out);
      if (int'(wave_out) > mx) mx = int'(wave_out);
    end
    chk("sine_max", 32'(mx), 32'd255);
    chk("sine_min", 32'(mn), 32'd0);
    release dut.tw_q;

    // Reset while the 5000 Hz conversion sits in C2
    do_load(4'd5, 4'd0, 4'd0, 4'd0);
    tick(2);
    rstn = 1'b0;
    #1;
    chk("abort_wave", 32'(wave_out), 32'h80);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_freq_bin", 32'(freq_bin), 32'd0);
    chk("abort_bcd_err", 32'(bcd_err), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick(12);
    chk("post_abort_freq_bin", 32'(freq_bin), 32'd0);
    chk("post_abort_tw", dut.tw_q, 32'd0);
    chk("post_abort_busy", 32'(busy), 32'd0);
    chk("post_abort_wave", 32'(wave_out), 32'h80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dds_wave_gen.md
# dds_wave_gen

Direct digital synthesis source that produces the 8-bit `wave_out` sample stream measured by the frequency meter. It accepts a 4-digit BCD frequency setpoint (0–9999 Hz), converts it sequentially to a 32-bit phase tuning word, and runs a phase accumulator that drives sine, square, triangle or sawtooth shaping. For every waveform, `wave_out[7]` rises exactly once per output period, so the meter's MSB edge count reads back the setpoint.

## Interface
- `CLK_HZ`, 50_000_000: `clk` frequency in Hz.
- `K_Q16`, round(2^48 / CLK_HZ) = 5629500: Hz-to-tuning-word factor, Q16 fixed point.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `freq_thou`, `freq_hund`, `freq_ten`, `freq_one`  in  4 each  BCD setpoint digits.
- `freq_load`  in  1  single-cycle request to take the digits.
- `wave_sel`  in  2  0 sine, 1 square, 2 triangle, 3 sawtooth.
- `wave_out`  out  8  unsigned offset-binary sample; midscale is 0x80.
- `freq_bin`  out  14  binary value of the last committed setpoint.
- `busy`  out  1  conversion in progress.
- `bcd_err`  out  1  last load was rejected because a digit was above 9.

## Operation
- Control FSM states: IDLE → C0 → C1 → C2 → C3 → MUL → COMMIT → IDLE.
- **IDLE**, `freq_load`=1:
  - If every digit is ≤ 9: latch all four digits, clear `bcd_err`, go to C0.
  - Otherwise: set `bcd_err`, stay in IDLE. The tuning word and `freq_bin` are unchanged.
- **C0**: acc = thou. **C1**: acc = acc·10 + hund. **C2**: acc = acc·10 + ten. **C3**: acc = acc·10 + one. acc is 14 bits; the maximum value is 9999.
- **MUL**: prod = acc × K_Q16. prod is 37 bits and unsigned.
- **COMMIT**: tw = prod >> 16, zero-extended to 32 bits. `freq_bin` = acc. Return to IDLE.
- `freq_load` is ignored in every state except IDLE. Digits may change freely after the load edge.
- Phase accumulator: `phase <= phase + tw` every cycle, mod 2^32. Retuning is phase-continuous; the phase is never cleared except by reset.
- Shaping uses p = phase[31:24], half h = phase[31], quadrant q = phase[31:30]:
  - **Sine**: i = phase[29:24] in quadrants 0 and 2, and i = ~phase[29:24] in quadrants 1 and 3. s = LUT[i], where LUT[i] = round(127·sin(π·i/128)) for i = 0..63. Output = h ? 127−s : 128+s.
  - **Square**: h ? 0x00 : 0xFF.
  - **Triangle**: t = phase[30] ? ~phase[29:23] : phase[29:23] (7 bits). Output = h ? 127−t : 128+t.
  - **Sawtooth**: p ^ 0x80.
- Invariant for all four shapes: `wave_out[7]` = ~h of the phase that produced the sample. There is one MSB rising edge per accumulator wrap.
- tw = 0 (setpoint 0) holds a constant sample.

## Timing
- Reset values: phase 0, tw 0, acc 0, FSM IDLE, `wave_out` 0x80, `freq_bin` 0, `busy` 0, `bcd_err` 0.
- Asserting reset mid-conversion aborts the conversion and discards the pending setpoint.
- Load latency: a load accepted at edge 0 updates tw and `freq_bin` at edge 6.
- `busy` is registered as (state ≠ IDLE). It is high after edges 0–5, i.e. for 6 cycles. A new load is accepted at edge 6 or later.
- The first phase increment using the new tw occurs at edge 7.
- `bcd_err` updates at the load edge and holds until the next accepted or rejected load.
- Output pipeline, 2 stages:
  - Stage 1 registers {phase[31:23], `wave_sel`} and the LUT address.
  - Stage 2 registers `wave_out`.
  - The sample at edge n+2 reflects the phase at edge n and `wave_sel` sampled at edge n+1.
- A `wave_sel` change takes effect within 2 cycles with no intermediate mixed-shape sample.

## Structure
- Package `dds_pkg` holds:
  - `PHASE_W` = 32.
  - `CLK_HZ` and `K_Q16` defaults, with the K_Q16 derivation documented.
  - An enum `wave_sel_t` {SINE, SQUARE, TRI, SAW}.
  - An enum `dds_state_t` for the seven FSM states.
  - A 4-bit `bcd_digit_t` typedef.
- Sub-module `dds_sine_lut`: a 64×7-bit quarter-wave ROM with a registered output, fed by the stage-1 address.
- The top level holds the FSM, the BCD/multiply datapath, the phase accumulator and the shaping mux.

## Test plan
- Reset release with no load: `wave_out` = 0x80 in sine, `busy` = 0, `freq_bin` = 0; the output stays constant for 1000 cycles.
- Load 1,0,0,0 with sine: `busy` is high exactly 6 cycles, `freq_bin` = 1000, tw = 85899. Over 200000 cycles, `wave_out[7]` rising edges are 50000±1 cycles apart.
- Load 9,9,9,9: tw = 858907, `freq_bin` = 9999. Then load 0,0,0,1 during `busy`: that load is ignored and `freq_bin` stays 9999.
- Load 1,2,A,4: `bcd_err` = 1, `busy` stays 0, tw is unchanged. A following load of 0,0,5,0 clears `bcd_err` and commits `freq_bin` = 50.
- Force tw = 0x01000000 and step `wave_sel` through 0–3:
  - Sawtooth samples are 0x80, 0x81, … 0xFF, 0x00, …
  - Square is 0xFF×128 then 0x00×128.
  - Triangle peaks at 255 and bottoms at 0.
  - The sine minimum is 0 and the maximum is 255.
- Assert `rstn` at the C2 step of a load of 5,0,0,0: all outputs return to reset values immediately, and after release `freq_bin` = 0 and tw = 0.
